ppu_row_mixer: RTL and testbench
================================

// Module: ppu_row_mixer
// PURPOSE
//  Composites one display row from the BG tile engine, FG tile engine and sprite engine row buffers.
//  Sits between those engines and row_ram_swap inside ppu_logic.
//  Once all three engines report done, it sweeps pixel addresses 0..ROW_WIDTH-1 and resolves
//  priority/transparency per pixel. Each result is written as a 10-bit colour reference into the
//  back row RAM, which hdmi_video_output later reads.
// PARAMETERS
//  ROW_WIDTH   320  visible pixels per row; sweep length
//  RD_LATENCY  1    cycles from pixel_addr to valid engine pixel data
// PORTS
//  clk                 in   1   system clock
//  rst_n               in   1   reset, asynchronous, active-low
//  pixel_addr          out  9   pixel index to all engine row buffers
//  bg_pixel_data       in   8   BG pixel {pal[5:0],col[1:0]}; col==0 transparent
//  fg_pixel_data       in   8   FG pixel, same format
//  sp_pixel_data       in   9   sprite pixel {pal[6:0],col[1:0]}; col==0 transparent
//  sp_pixel_prio       in   2   sprite priority: 00 off, 01 below BG, 10 BG<sp<FG, 11 above FG
//  bgte_done           in   1   BG row buffer complete (level; drops on next prep)
//  fgte_done           in   1   FG row buffer complete (level)
//  spre_done           in   1   sprite row buffer complete (level)
//  pmxr_rowram_wrdata  out  10  composited colour reference
//  pmxr_rowram_wraddr  out  9   row RAM write address (= pixel index)
//  pmxr_rowram_wren    out  1   row RAM write strobe
// BEHAVIOUR
//  Reset values (async, rst_n=0): state=IDLE; pixel_addr=0; wren=0; wraddr=0; wrdata=0.
//  all_done = bgte_done & fgte_done & spre_done.
//  FSM:
//   IDLE  -> RUN when all_done==1; pixel counter cleared.
//   RUN   -> drives pixel_addr = 0,1,..,ROW_WIDTH-1 on consecutive cycles, one per clock.
//         -> goes to HOLD after the last address issues and the pipeline drains.
//   HOLD  -> IDLE once all_done==0, i.e. the next prep has begun. Exactly one sweep per row.
//   all_done falling during RUN (row budget overrun): abort to IDLE.
//         -> in-flight pipeline writes are squashed; no further wren for that row.
//  Pipeline:
//   addr a issued cycle t; engine data valid cycle t+RD_LATENCY.
//   Composite is registered; wren/wraddr=a/wrdata appear cycle t+RD_LATENCY+1.
//   Row time = ROW_WIDTH+RD_LATENCY+1 cycles (322 at defaults).
//   wren is high exactly ROW_WIDTH cycles per row, addresses strictly ascending with no gaps.
//   wraddr/wrdata hold their last values when wren=0.
//  Composite (per pixel), checked in order; a layer is eligible only if its col!=0:
//   1. sprite if prio==11
//   2. FG    -> {2'b01, fg[7:0]}
//   3. sprite if prio==10
//   4. BG    -> {2'b00, bg[7:0]}
//   5. sprite if prio==01
//   6. else backdrop -> 10'd0
//   sprite -> {1'b1, sp[8:0]}; prio==00 sprite never eligible.
//  Note: BG pal 0/col 0 can never encode, so 10'd0 uniquely denotes backdrop.
//  pixel_addr stays 9 bits; it never reaches ROW_WIDTH; it rests at 0 in IDLE/HOLD.
//  all_done already high on reset release: sweep starts the cycle after reset deasserts.
// STRUCTURE
//  ppu_pkg: typedefs tile_pix_t (8b), spr_pix_t (9b), rowram_word_t (10b), spr_prio_e enum;
//   constants ROW_WIDTH_DEF=320, layer tag values.
//  Sub-module ppu_mixer_prio: purely combinational priority resolver (steps 1-6),
//   reused by the bench as the reference model.
//  Top holds FSM, pixel counter, RD_LATENCY-deep valid/addr shift register, output registers.
// TESTING
//  1. All engines done, bg=0x05, fg=0x00, sp col=0 -> 320 writes of wrdata 0x005.
//     Addresses 0..319 contiguous; first wren 2 cycles after addr 0.
//  2. Per-pixel table check, bg=0x09, fg=0x0E, sp=0x1F3:
//     prio 11 -> 0x3F3; prio 10 -> 0x10E; fg col=0 & prio 10 -> 0x3F3;
//     prio 01 with bg opaque -> 0x009; all transparent -> 0x000.
//  3. Done handshake: keep done high after sweep for 1000 cycles -> no second sweep.
//     Drop then raise all_done -> exactly one new 320-write sweep.
//  4. Staggered done (bg t0, fg t5, sp t40) -> first pixel_addr issue only after t40.
//  5. Abort: drop fgte_done at pixel 100 -> wren ceases within RD_LATENCY+1 cycles; FSM IDLE.
//     Next all_done -> full fresh sweep from 0.
//  6. Assert rst_n=0 mid-sweep -> outputs zero immediately, asynchronously.
//     Release with done high -> clean sweep from addr 0.

Source files
------------

// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppu_pkg
// Description : Shared pixel types, sprite priority codes and layer tags for
//               the PPU row compositor.
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    localparam int ROW_WIDTH_DEF = 320;

    typedef logic [7:0] tile_pix_t;     // {pal[5:0], col[1:0]}
    typedef logic [8:0] spr_pix_t;      // {pal[6:0], col[1:0]}
    typedef logic [9:0] rowram_word_t;  // composited colour reference

    typedef enum logic [1:0] {
        PRIO_OFF      = 2'b00,
        PRIO_BELOW_BG = 2'b01,
        PRIO_MID      = 2'b10,
        PRIO_TOP      = 2'b11
    } spr_prio_e;

    // Upper bits of the row RAM word identify the source layer
    localparam logic [1:0]   c_tag_bg   = 2'b00;
    localparam logic [1:0]   c_tag_fg   = 2'b01;
    localparam logic         c_tag_sp   = 1'b1;
    localparam rowram_word_t c_backdrop = 10'd0;

endpackage
`default_nettype wire

// File: rtl/ppu_mixer_prio.sv
`default_nettype none
// ============================================================================
// Module      : ppu_mixer_prio
// Description : Combinational per-pixel priority/transparency resolver for
//               the BG, FG and sprite layers.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_mixer_prio (
    input  logic [7:0] i_bg_pix,
    input  logic [7:0] i_fg_pix,
    input  logic [8:0] i_sp_pix,
    input  logic [1:0] i_sp_prio,
    output logic [9:0] o_mix
);
    import ppu_pkg::*;

    logic      w_bg_opq;
    logic      w_fg_opq;
    logic      w_sp_opq;
    spr_prio_e w_prio;

    assign w_bg_opq = (i_bg_pix[1:0] != 2'b00);
    assign w_fg_opq = (i_fg_pix[1:0] != 2'b00);
    assign w_sp_opq = (i_sp_pix[1:0] != 2'b00);
    assign w_prio   = spr_prio_e'(i_sp_prio);

    always_comb begin
        o_mix = c_backdrop;
        if (w_sp_opq && (w_prio == PRIO_TOP)) begin
            o_mix = {c_tag_sp, i_sp_pix};
        end else if (w_fg_opq) begin
            o_mix = {c_tag_fg, i_fg_pix};
        end else if (w_sp_opq && (w_prio == PRIO_MID)) begin
            o_mix = {c_tag_sp, i_sp_pix};
        end else if (w_bg_opq) begin
            o_mix = {c_tag_bg, i_bg_pix};
        end else if (w_sp_opq && (w_prio == PRIO_BELOW_BG)) begin
            o_mix = {c_tag_sp, i_sp_pix};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppu_row_mixer.sv
`default_nettype none
// ============================================================================
// Module      : ppu_row_mixer
// Description : Sweeps the engine row buffers once per row and writes the
//               composited colour references into the back row RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_row_mixer
    import ppu_pkg::*;
#(
    parameter int ROW_WIDTH  = ROW_WIDTH_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [8:0] pixel_addr,
    input  logic [7:0] bg_pixel_data,
    input  logic [7:0] fg_pixel_data,
    input  logic [8:0] sp_pixel_data,
    input  logic [1:0] sp_pixel_prio,
    input  logic       bgte_done,
    input  logic       fgte_done,
    input  logic       spre_done,
    output logic [9:0] pmxr_rowram_wrdata,
    output logic [8:0] pmxr_rowram_wraddr,
    output logic       pmxr_rowram_wren
);

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_run       = 2'd1;
    localparam logic [1:0] c_hold      = 2'd2;
    localparam logic [8:0] c_last_addr = 9'(ROW_WIDTH - 1);

    logic [1:0]            r_state;
    logic                  r_issue;
    logic [RD_LATENCY-1:0] r_vld_sr;
    logic [8:0]            r_addr_sr [RD_LATENCY];

    logic                  w_all_done;
    logic                  w_abort;
    logic                  w_pipe_busy;
    logic                  w_wr_fire;
    rowram_word_t          w_mix;

    assign w_all_done  = bgte_done & fgte_done & spre_done;
    assign w_abort     = (r_state == c_run) && !w_all_done;
    assign w_pipe_busy = |r_vld_sr;
    assign w_wr_fire   = r_vld_sr[RD_LATENCY-1] && !w_abort;

    // r_issue marks that pixel_addr carries a live address this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_issue    <= 1'b0;
            pixel_addr <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_all_done) begin
                        r_state    <= c_run;
                        r_issue    <= 1'b1;
                        pixel_addr <= '0;
                    end
                end
                c_run: begin
                    if (!w_all_done) begin
                        r_state    <= c_idle;
                        r_issue    <= 1'b0;
                        pixel_addr <= '0;
                    end else if (r_issue) begin
                        if (pixel_addr == c_last_addr) begin
                            r_issue    <= 1'b0;
                            pixel_addr <= '0;
                        end else begin
                            pixel_addr <= pixel_addr + 9'd1;
                        end
                    end else if (!w_pipe_busy) begin
                        r_state <= c_hold;
                    end
                end
                c_hold: begin
                    if (!w_all_done) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state    <= c_idle;
                    r_issue    <= 1'b0;
                    pixel_addr <= '0;
                end
            endcase
        end
    end

    // Tracks each issued address until its engine data is valid; an abort
    // clears every in-flight entry so nothing more is written for the row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_sr <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_addr_sr[i] <= '0;
            end
        end else begin
            r_vld_sr[0]  <= r_issue && !w_abort;
            r_addr_sr[0] <= pixel_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld_sr[i]  <= r_vld_sr[i-1] && !w_abort;
                r_addr_sr[i] <= r_addr_sr[i-1];
            end
        end
    end

    ppu_mixer_prio u_prio (
        .i_bg_pix  (bg_pixel_data),
        .i_fg_pix  (fg_pixel_data),
        .i_sp_pix  (sp_pixel_data),
        .i_sp_prio (sp_pixel_prio),
        .o_mix     (w_mix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmxr_rowram_wren   <= 1'b0;
            pmxr_rowram_wraddr <= '0;
            pmxr_rowram_wrdata <= '0;
        end else begin
            pmxr_rowram_wren <= w_wr_fire;
            if (w_wr_fire) begin
                pmxr_rowram_wraddr <= r_addr_sr[RD_LATENCY-1];
                pmxr_rowram_wrdata <= w_mix;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppu_row_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppu_row_mixer
// Description : Directed self-checking bench for ppu_row_mixer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_row_mixer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] pixel_addr;
    logic [7:0] bg_pixel_data = '0;
    logic [7:0] fg_pixel_data = '0;
    logic [8:0] sp_pixel_data = '0;
    logic [1:0] sp_pixel_prio = '0;
    logic       bgte_done;
    logic       fgte_done;
    logic       spre_done;
    logic [9:0] pmxr_rowram_wrdata;
    logic [8:0] pmxr_rowram_wraddr;
    logic       pmxr_rowram_wren;

    logic [7:0] bg_ram  [320];
    logic [7:0] fg_ram  [320];
    logic [8:0] sp_ram  [320];
    logic [1:0] pr_ram  [320];
    logic [9:0] exp_ram [320];

    logic [8:0] log_addr [$];
    logic [9:0] log_data [$];

    int checks = 0;
    int errors = 0;

    ppu_row_mixer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pixel_addr         (pixel_addr),
        .bg_pixel_data      (bg_pixel_data),
        .fg_pixel_data      (fg_pixel_data),
        .sp_pixel_data      (sp_pixel_data),
        .sp_pixel_prio      (sp_pixel_prio),
        .bgte_done          (bgte_done),
        .fgte_done          (fgte_done),
        .spre_done          (spre_done),
        .pmxr_rowram_wrdata (pmxr_rowram_wrdata),
        .pmxr_rowram_wraddr (pmxr_rowram_wraddr),
        .pmxr_rowram_wren   (pmxr_rowram_wren)
    );

    always #5 clk = ~clk;

    // Engine row buffers with a one-cycle registered read
    always @(posedge clk) begin
        bg_pixel_data <= bg_ram[pixel_addr];
        fg_pixel_data <= fg_ram[pixel_addr];
        sp_pixel_data <= sp_ram[pixel_addr];
        sp_pixel_prio <= pr_ram[pixel_addr];
    end

    always @(posedge clk) begin
        #1;
        if (pmxr_rowram_wren === 1'b1) begin
            log_addr.push_back(pmxr_rowram_wraddr);
            log_data.push_back(pmxr_rowram_wrdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    function automatic logic [9:0] logged_data(input int idx);
        return (idx < log_data.size()) ? log_data[idx] : 10'h3FF;
    endfunction

    task automatic wait_sweep(input string tag);
        int guard = 0;
        while (log_addr.size() < 320 && guard < 2000) begin
            tick(1);
            guard++;
        end
        tick(4);
        chk({tag, "_timeout"}, 32'(guard < 2000), 32'd1);
    endtask

    task automatic wait_addr(input string tag, input logic [8:0] a);
        int guard = 0;
        while (pixel_addr !== a && guard < 1000) begin
            tick(1);
            guard++;
        end
        chk({tag, "_reach_addr"}, pixel_addr, a);
    endtask

    task automatic check_sweep(input string tag, input int n);
        int bad   = 0;
        int first = -1;
        chk({tag, "_write_count"}, log_addr.size(), n);
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_addr[i] !== 9'(i) || log_data[i] !== exp_ram[i % 320]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        chk({tag, "_bad_entries"}, bad, 0);
        if (first >= 0) begin
            chk({tag, "_first_bad_addr"}, log_addr[first], first);
            chk({tag, "_first_bad_data"}, log_data[first], exp_ram[first % 320]);
        end
    endtask

    initial begin
        int early;
        int n_abort;
        logic [8:0] a;

        rst_n     = 1'b0;
        bgte_done = 1'b0;
        fgte_done = 1'b0;
        spre_done = 1'b0;
        // Row 1: opaque BG only; sprite pixels opaque-prio but col 0
        for (int i = 0; i < 320; i++) begin
            bg_ram[i]  = 8'h05;
            fg_ram[i]  = 8'h00;
            sp_ram[i]  = 9'h1F0;
            pr_ram[i]  = 2'b11;
            exp_ram[i] = 10'h005;
        end
        tick(3);
        chk("reset_pixel_addr", pixel_addr, 9'd0);
        chk("reset_wren", pmxr_rowram_wren, 1'b0);
        chk("reset_wraddr", pmxr_rowram_wraddr, 9'd0);
        chk("reset_wrdata", pmxr_rowram_wrdata, 10'd0);

        rst_n = 1'b1;
        tick(2);
        chk("idle_pixel_addr", pixel_addr, 9'd0);

        // Staggered done: nothing may issue until the sprite engine finishes
        early = 0;
        bgte_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) fgte_done = 1'b1;
            tick(1);
            if (pixel_addr !== 9'd0 || pmxr_rowram_wren !== 1'b0) early++;
        end
        chk("stagger_early_activity", early, 0);

        clear_log();
        spre_done = 1'b1;
        tick(1);
        chk("first_issue_addr0", pixel_addr, 9'd0);
        tick(1);
        chk("second_issue_addr1", pixel_addr, 9'd1);
        chk("latency_no_wren_yet", pmxr_rowram_wren, 1'b0);
        tick(1);
        chk("latency_first_wren", pmxr_rowram_wren, 1'b1);
        chk("latency_first_wraddr", pmxr_rowram_wraddr, 9'd0);
        chk("latency_first_wrdata", pmxr_rowram_wrdata, 10'h005);
        wait_sweep("sweep1");
        check_sweep("sweep1", 320);
        chk("sweep1_wraddr_held", pmxr_rowram_wraddr, 9'd319);

        // Done stays high: exactly one sweep per row
        tick(1000);
        chk("hold_no_resweep", log_addr.size(), 320);
        chk("hold_pixel_addr", pixel_addr, 9'd0);

        // Row 2: priority table at pixels 0..8, plain BG elsewhere
        for (int i = 0; i < 320; i++) begin
            a = 9'(i);
            bg_ram[i]  = {a[5:0], 2'b01};
            fg_ram[i]  = 8'h00;
            sp_ram[i]  = 9'h000;
            pr_ram[i]  = 2'b00;
            exp_ram[i] = {2'b00, a[5:0], 2'b01};
        end
        bg_ram[0] = 8'h09; fg_ram[0] = 8'h0E; sp_ram[0] = 9'h1F3; pr_ram[0] = 2'b11; exp_ram[0] = 10'h3F3;
        bg_ram[1] = 8'h09; fg_ram[1] = 8'h0E; sp_ram[1] = 9'h1F3; pr_ram[1] = 2'b10; exp_ram[1] = 10'h10E;
        bg_ram[2] = 8'h09; fg_ram[2] = 8'h0C; sp_ram[2] = 9'h1F3; pr_ram[2] = 2'b10; exp_ram[2] = 10'h3F3;
        bg_ram[3] = 8'h09; fg_ram[3] = 8'h0C; sp_ram[3] = 9'h1F3; pr_ram[3] = 2'b01; exp_ram[3] = 10'h009;
        bg_ram[4] = 8'h08; fg_ram[4] = 8'h0C; sp_ram[4] = 9'h1F0; pr_ram[4] = 2'b11; exp_ram[4] = 10'h000;
        bg_ram[5] = 8'h08; fg_ram[5] = 8'h0C; sp_ram[5] = 9'h1F3; pr_ram[5] = 2'b01; exp_ram[5] = 10'h3F3;
        bg_ram[6] = 8'h09; fg_ram[6] = 8'h0E; sp_ram[6] = 9'h1F3; pr_ram[6] = 2'b00; exp_ram[6] = 10'h10E;
        bg_ram[7] = 8'h09; fg_ram[7] = 8'h0C; sp_ram[7] = 9'h1F3; pr_ram[7] = 2'b00; exp_ram[7] = 10'h009;
        bg_ram[8] = 8'h08; fg_ram[8] = 8'h0C; sp_ram[8] = 9'h1F3; pr_ram[8] = 2'b00; exp_ram[8] = 10'h000;

        spre_done = 1'b0;
        tick(3);
        chk("handshake_idle_addr", pixel_addr, 9'd0);
        clear_log();
        spre_done = 1'b1;
        wait_sweep("table");
        check_sweep("table", 320);
        chk("tbl_sp_prio11_over_fg", logged_data(0), 10'h3F3);
        chk("tbl_fg_over_sp_prio10", logged_data(1), 10'h10E);
        chk("tbl_sp_prio10_fg_clear", logged_data(2), 10'h3F3);
        chk("tbl_bg_over_sp_prio01", logged_data(3), 10'h009);
        chk("tbl_all_transparent", logged_data(4), 10'h000);
        chk("tbl_sp_prio01_bg_clear", logged_data(5), 10'h3F3);
        chk("tbl_sp_prio00_ignored", logged_data(8), 10'h000);

        // Abort: FG engine drops done mid-row
        spre_done = 1'b0;
        tick(3);
        clear_log();
        spre_done = 1'b1;
        wait_addr("abort", 9'd100);
        fgte_done = 1'b0;
        tick(2);
        chk("abort_wren_low", pmxr_rowram_wren, 1'b0);
        n_abort = log_addr.size();
        chk("abort_write_count_range", 32'(n_abort >= 99 && n_abort <= 101), 32'd1);
        check_sweep("abort_partial", n_abort);
        tick(20);
        chk("abort_no_more_writes", log_addr.size(), n_abort);
        chk("abort_pixel_addr_idle", pixel_addr, 9'd0);
        clear_log();
        fgte_done = 1'b1;
        wait_sweep("post_abort");
        check_sweep("post_abort", 320);

        // Asynchronous reset in the middle of a sweep
        spre_done = 1'b0;
        tick(3);
        clear_log();
        spre_done = 1'b1;
        wait_addr("areset", 9'd50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_wren", pmxr_rowram_wren, 1'b0);
        chk("areset_pixel_addr", pixel_addr, 9'd0);
        chk("areset_wraddr", pmxr_rowram_wraddr, 9'd0);
        chk("areset_wrdata", pmxr_rowram_wrdata, 10'd0);
        tick(2);
        clear_log();
        rst_n = 1'b1;
        wait_sweep("post_reset");
        check_sweep("post_reset", 320);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
